scan_decoder: RTL and testbench

Registered, parametrised N-to-2^N decoder: the successor to the combinational 5-to-32 enable decoder. Adds one-hot, thermometer and self-scanning modes plus a load strobe and a wrap indicator. Drives multiplexed displays, LED banks and chip-select lines from a single index register. Sits between control logic and board I/O in the lab designs.

---
 rtl/scan_decoder_pkg.sv | 15 +
 rtl/scan_tick.sv | 28 ++
 rtl/scan_decoder.sv | 99 +++++++++
 tb/tb_scan_decoder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/scan_decoder_pkg.sv
// Shared mode encodings and width helper for the scan decoder.
package scan_decoder_pkg;

  typedef enum logic [1:0] {
    MODE_ONEHOT = 2'b00,
    MODE_THERMO = 2'b01,
    MODE_SCAN   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_t;

  function automatic int outWidth(input int selW);
    return 1 << selW;
  endfunction

endpackage

// File: rtl/scan_tick.sv
// Scan prescaler: emits a one-cycle tick every SCAN_DIV running cycles; tick is combinational from the count.
// No backpressure: run low holds the count, clear restarts the dwell.
module scan_tick #(
  parameter int SCAN_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

  logic [PRE_W-1:0] pre;

  assign tick = run && !clear && (pre == PRE_LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pre <= '0;
    end else if (run) begin
      pre <= tick ? '0 : pre + 1'b1;
    end
  end

endmodule

// File: rtl/scan_decoder.sv
// Registered N-to-2^N decoder (one-hot/thermometer/scan/hold); 1-cycle latency, no backpressure, iEna blanks and pauses.
// SCAN_DECODER_ACTIVE_LOW_EN inverts oData (active channels read 0, blank/reset value all ones).
import scan_decoder_pkg::*;

module scan_decoder #(
  parameter int SEL_W     = 5,
  parameter int SCAN_DIV  = 4,
  parameter int SCAN_LAST = 2**SEL_W - 1
) (
  input  logic                          iClk,
  input  logic                          iRst,
  input  logic                          iEna,
  input  logic [1:0]                    iMode,
  input  logic                          iLoad,
  input  logic [SEL_W-1:0]              iData,
  output logic [outWidth(SEL_W)-1:0]    oData,
  output logic [SEL_W-1:0]              oIndex,
  output logic                          oWrap
);

  localparam int OUT_W = outWidth(SEL_W);
`ifdef SCAN_DECODER_ACTIVE_LOW_EN
  localparam logic ACTIVE_LOW = 1'b1;
`else
  localparam logic ACTIVE_LOW = 1'b0;
`endif
  // Doubles as the blank/reset value and the XOR mask applied to decoded data.
  localparam logic [OUT_W-1:0] POL_MASK = {OUT_W{ACTIVE_LOW}};

  mode_t            mode;
  mode_t            prevMode;
  logic [SEL_W-1:0] idx;
  logic [SEL_W-1:0] idxNext;
  logic             wrapNext;
  logic [OUT_W-1:0] decoded;
  logic             loadEn;
  logic             scanClear;
  logic             scanRun;
  logic             tick;

  assign mode      = mode_t'(iMode);
  assign loadEn    = iLoad && (mode != MODE_HOLD);
  assign scanClear = (mode == MODE_SCAN) && (loadEn || (prevMode != MODE_SCAN));
  assign scanRun   = (mode == MODE_SCAN) && iEna;
  assign oIndex    = idx;

  scan_tick #(.SCAN_DIV(SCAN_DIV)) uTick (
    .clk   (iClk),
    .rst   (iRst),
    .clear (scanClear),
    .run   (scanRun),
    .tick  (tick)
  );

  always_comb begin
    idxNext  = idx;
    wrapNext = 1'b0;
    if (loadEn) begin
      idxNext = iData;
    end else if (tick) begin
      // Indices loaded beyond SCAN_LAST also wrap straight back to 0.
      if (idx >= SEL_W'(SCAN_LAST)) begin
        idxNext  = '0;
        wrapNext = 1'b1;
      end else begin
        idxNext = idx + 1'b1;
      end
    end
  end

  always_comb begin
    decoded = '0;
    for (int i = 0; i < OUT_W; i++) begin
      if (mode == MODE_THERMO) begin
        decoded[i] = (SEL_W'(i) <= idxNext);
      end else begin
        decoded[i] = (SEL_W'(i) == idxNext);
      end
    end
  end

  always_ff @(posedge iClk) begin
    prevMode <= mode;
    if (iRst) begin
      idx   <= '0;
      oWrap <= 1'b0;
      oData <= POL_MASK;
    end else begin
      idx   <= idxNext;
      oWrap <= wrapNext;
      if (!iEna) begin
        oData <= POL_MASK;
      end else if (mode != MODE_HOLD) begin
        oData <= decoded ^ POL_MASK;
      end
    end
  end

endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder: constant vector table, closed-form scan sequences, randomized run against a dwell model.
module tb_scan_decoder;
  import scan_decoder_pkg::*;

  localparam int SCAN_DIV  = 4;
  localparam int SCAN_LAST = 7;
`ifdef SCAN_DECODER_ACTIVE_LOW_EN
  localparam logic [31:0] POL = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] POL = 32'h0000_0000;
`endif

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        iEna = 1'b0;
  logic [1:0]  iMode = 2'b00;
  logic        iLoad = 1'b0;
  logic [4:0]  iData = 5'd0;
  logic [31:0] oData;
  logic [4:0]  oIndex;
  logic        oWrap;

  int nTests = 0;
  int nFail  = 0;

  always #5 iClk = ~iClk;

  scan_decoder #(.SEL_W(5), .SCAN_DIV(SCAN_DIV), .SCAN_LAST(SCAN_LAST)) dut (
    .iClk   (iClk),
    .iRst   (iRst),
    .iEna   (iEna),
    .iMode  (iMode),
    .iLoad  (iLoad),
    .iData  (iData),
    .oData  (oData),
    .oIndex (oIndex),
    .oWrap  (oWrap)
  );

  typedef struct {
    logic        rst;
    logic        ena;
    logic [1:0]  mode;
    logic        load;
    logic [4:0]  data;
    logic [4:0]  expIdx;
    logic [31:0] expData;
    logic        expWrap;
  } vec_t;

  vec_t vecs[11];

  // Reference model: a channel is shown for SCAN_DIV running cycles, counted as elapsed cycles in the dwell.
  int          mIdx;
  int          mDwell;
  logic [1:0]  mPrev;
  logic        mWrap;
  logic [31:0] mData;

  function automatic logic [31:0] dec(input logic [1:0] m, input int idx);
    logic [63:0] w;
    w = 64'd1 << idx;
    if (m == MODE_THERMO) return 32'((w << 1) - 64'd1);
    return 32'(w);
  endfunction

  task automatic modelStep();
    if (iRst) begin
      mIdx = 0; mDwell = 0; mWrap = 1'b0; mData = POL;
    end else begin
      mWrap = 1'b0;
      if (iMode == MODE_HOLD) begin
        if (!iEna) mData = POL;
      end else begin
        if (iMode == MODE_SCAN && (iLoad || mPrev != MODE_SCAN)) mDwell = 0;
        if (iLoad) begin
          mIdx = int'(iData);
        end else if (iMode == MODE_SCAN && iEna && mPrev == MODE_SCAN) begin
          mDwell = mDwell + 1;
          if (mDwell == SCAN_DIV) begin
            mDwell = 0;
            if (mIdx >= SCAN_LAST) begin mIdx = 0; mWrap = 1'b1; end
            else mIdx = mIdx + 1;
          end
        end
        mData = iEna ? (dec(iMode, mIdx) ^ POL) : POL;
      end
    end
    mPrev = iMode;
  endtask

  task automatic step();
    @(posedge iClk);
    modelStep();
    #1;
  endtask

  task automatic drive(input logic r, input logic e, input logic [1:0] m, input logic l, input logic [4:0] d);
    iRst = r; iEna = e; iMode = m; iLoad = l; iData = d;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b1, MODE_ONEHOT, 1'b0, 5'd0,  5'd0,  32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, MODE_ONEHOT, 1'b1, 5'd5,  5'd5,  32'h0000_0020, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, MODE_ONEHOT, 1'b1, 5'd31, 5'd31, 32'h8000_0000, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, MODE_THERMO, 1'b1, 5'd3,  5'd3,  32'h0000_000F, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, MODE_THERMO, 1'b1, 5'd0,  5'd0,  32'h0000_0001, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, MODE_THERMO, 1'b1, 5'd31, 5'd31, 32'hFFFF_FFFF, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, MODE_ONEHOT, 1'b0, 5'd2,  5'd31, 32'h8000_0000, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, MODE_HOLD,   1'b1, 5'd4,  5'd31, 32'h8000_0000, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, MODE_ONEHOT, 1'b1, 5'd9,  5'd9,  32'h0000_0000, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, MODE_THERMO, 1'b0, 5'd0,  5'd9,  32'h0000_03FF, 1'b0};
    vecs[10] = '{1'b1, 1'b1, MODE_THERMO, 1'b1, 5'd17, 5'd0,  32'h0000_0000, 1'b0};

    for (int v = 0; v < 11; v++) begin
      drive(vecs[v].rst, vecs[v].ena, vecs[v].mode, vecs[v].load, vecs[v].data);
      step();
      chk($sformatf("vec%0d idx", v),  32'(oIndex), 32'(vecs[v].expIdx));
      chk($sformatf("vec%0d data", v), oData, vecs[v].expData ^ POL);
      chk($sformatf("vec%0d wrap", v), 32'(oWrap), 32'(vecs[v].expWrap));
    end

    // Full scan period from reset: 8 channels x 4 cycles, wrap pulse at cycle 32.
    drive(1'b1, 1'b1, MODE_SCAN, 1'b0, 5'd0);
    step();
    chk("scanRst idx", 32'(oIndex), 32'd0);
    chk("scanRst data", oData, POL);
    drive(1'b0, 1'b1, MODE_SCAN, 1'b0, 5'd0);
    for (int j = 1; j <= 33; j++) begin
      step();
      chk($sformatf("scan%0d idx", j), 32'(oIndex), 32'((j / 4) % 8));
      chk($sformatf("scan%0d wrap", j), 32'(oWrap), 32'(j == 32));
      chk($sformatf("scan%0d data", j), oData, (32'd1 << ((j / 4) % 8)) ^ POL);
    end

    // Load beyond SCAN_LAST: full dwell on 20, then wrap to 0.
    drive(1'b0, 1'b1, MODE_SCAN, 1'b1, 5'd20);
    step();
    drive(1'b0, 1'b1, MODE_SCAN, 1'b0, 5'd0);
    chk("ld20 idx", 32'(oIndex), 32'd20);
    for (int j = 1; j <= 5; j++) begin
      step();
      chk($sformatf("ld20+%0d idx", j), 32'(oIndex), (j < 4) ? 32'd20 : 32'd0);
      chk($sformatf("ld20+%0d wrap", j), 32'(oWrap), 32'(j == 4));
    end

    // Enable drop mid-dwell: blanked, index and dwell position held.
    drive(1'b1, 1'b1, MODE_SCAN, 1'b0, 5'd0);
    step();
    drive(1'b0, 1'b1, MODE_SCAN, 1'b0, 5'd0);
    step();
    step();
    chk("preEna idx", 32'(oIndex), 32'd0);
    drive(1'b0, 1'b0, MODE_SCAN, 1'b0, 5'd0);
    for (int j = 0; j < 10; j++) begin
      step();
      chk($sformatf("ena0 %0d data", j), oData, POL);
      chk($sformatf("ena0 %0d idx", j), 32'(oIndex), 32'd0);
      chk($sformatf("ena0 %0d wrap", j), 32'(oWrap), 32'd0);
    end
    drive(1'b0, 1'b1, MODE_SCAN, 1'b0, 5'd0);
    step();
    chk("ena1 a idx", 32'(oIndex), 32'd0);
    chk("ena1 a data", oData, 32'h1 ^ POL);
    step();
    chk("ena1 b idx", 32'(oIndex), 32'd1);
    chk("ena1 b data", oData, 32'h2 ^ POL);

    // Mid-scan reset pulse restarts at channel 0 with a full dwell.
    for (int j = 0; j < 4; j++) step();
    chk("preRst idx", 32'(oIndex), 32'd2);
    drive(1'b1, 1'b1, MODE_SCAN, 1'b1, 5'd6);
    step();
    chk("midRst idx", 32'(oIndex), 32'd0);
    chk("midRst data", oData, POL);
    chk("midRst wrap", 32'(oWrap), 32'd0);
    drive(1'b0, 1'b1, MODE_SCAN, 1'b0, 5'd0);
    for (int j = 1; j <= 4; j++) begin
      step();
      chk($sformatf("postRst%0d idx", j), 32'(oIndex), (j == 4) ? 32'd1 : 32'd0);
      chk($sformatf("postRst%0d wrap", j), 32'(oWrap), 32'd0);
    end
    chk("postRst data", oData, 32'h2 ^ POL);

    // Randomized traffic against the model.
    drive(1'b1, 1'b1, MODE_SCAN, 1'b0, 5'd0);
    step();
    for (int c = 0; c < 3000; c++) begin
      logic [1:0] m;
      m = iMode;
      if ($urandom_range(0, 15) == 0) begin
        m = ($urandom_range(0, 1) == 0) ? 2'(MODE_SCAN) : 2'($urandom_range(0, 3));
      end
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0), m,
            ($urandom_range(0, 9) == 0), 5'($urandom_range(0, 31)));
      step();
      chk($sformatf("rnd%0d idx", c), 32'(oIndex), 32'(mIdx));
      chk($sformatf("rnd%0d data", c), oData, mData);
      chk($sformatf("rnd%0d wrap", c), 32'(oWrap), 32'(mWrap));
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
